// File: rtl/req_client_bank_if.sv
// Request/grant handshake bundle between job sources, the client bank and the arbiter.
// The master side drives jobs, grants and the watchdog limit; the bank is the slave.
interface req_client_bank_if #(
  parameter int NCH = 8,
  parameter int CW  = 10,
  parameter int LW  = 4
);
  logic [NCH-1:0] job_v;
  logic [LW-1:0]  job_len;
  logic [NCH-1:0] gnt;
  logic [CW-1:0]  tmo_limit;
  logic [NCH-1:0] req;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;
  logic [NCH-1:0] to_err;
  logic [NCH-1:0] ovf;
  logic           gnt_err;

  modport master (
    output job_v, job_len, gnt, tmo_limit,
    input  req, busy, done, to_err, ovf, gnt_err
  );

  modport slave (
    input  job_v, job_len, gnt, tmo_limit,
    output req, busy, done, to_err, ovf, gnt_err
  );
endinterface

// File: rtl/req_client_bank.sv
// Bank of independent requester channels: each queues jobs, requests the arbiter,
// holds busy for the job length after a grant, and abandons jobs the watchdog times out.
module req_client_bank #(
  parameter int NCH = 8,
  parameter int CW  = 10,
  parameter int QD  = 3,
  parameter int LW  = 4
) (
  input logic              n0,
  input logic              n1,
  req_client_bank_if.slave bus
);

  localparam int PW = $clog2(QD + 1);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, DONE} state_t;

  logic [NCH-1:0] req_v, busy_v, done_v, to_err_v, ovf_v;
  logic           gnt_err_q;

  genvar i;
  for (i = 0; i < NCH; i++) begin : g_ch
    state_t          state, state_n;
    logic [LW-1:0]   mem [QD];
    logic [PW-1:0]   rd_ptr, wr_ptr, cnt;
    logic [LW-1:0]   len_q, bcnt;
    logic [CW-1:0]   wait_q;
    logic            deq, enq, drop, tmo_hit;
    logic            to_err_q, ovf_q;

    // A full queue still accepts a job on the edge its head leaves for REQ.
    always_comb begin
      deq     = (state == IDLE) && (cnt != '0);
      drop    = bus.job_v[i] && (cnt == PW'(QD)) && !deq;
      enq     = bus.job_v[i] && !drop;
      tmo_hit = (bus.tmo_limit != '0) && (wait_q == bus.tmo_limit - CW'(1));
      state_n = state;
      case (state)
        IDLE:    if (deq) state_n = REQ;
        REQ:     if (bus.gnt[i]) state_n = BUSY;
                 else if (tmo_hit) state_n = IDLE;
        BUSY:    if (bcnt == LW'(1)) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end

    always_ff @(posedge n0) begin
      if (enq) mem[wr_ptr] <= bus.job_len;
    end

    always_ff @(posedge n0 or posedge n1) begin
      if (n1) begin
        state    <= IDLE;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        cnt      <= '0;
        len_q    <= '0;
        bcnt     <= '0;
        wait_q   <= '0;
        to_err_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        state <= state_n;
        if (enq) wr_ptr <= (wr_ptr == PW'(QD - 1)) ? '0 : wr_ptr + PW'(1);
        if (deq) begin
          rd_ptr <= (rd_ptr == PW'(QD - 1)) ? '0 : rd_ptr + PW'(1);
          len_q  <= (mem[rd_ptr] == '0) ? LW'(1) : mem[rd_ptr];
          wait_q <= '0;
        end else if (state == REQ && wait_q != '1) begin
          wait_q <= wait_q + CW'(1);
        end
        case ({enq, deq})
          2'b10:   cnt <= cnt + PW'(1);
          2'b01:   cnt <= cnt - PW'(1);
          default: cnt <= cnt;
        endcase
        if (state == REQ && bus.gnt[i]) bcnt <= len_q;
        else if (state == BUSY)         bcnt <= bcnt - LW'(1);
        to_err_q <= (state == REQ) && !bus.gnt[i] && tmo_hit;
        ovf_q    <= drop;
      end
    end

    assign req_v[i]    = (state == REQ);
    assign busy_v[i]   = (state == BUSY);
    assign done_v[i]   = (state == DONE);
    assign to_err_v[i] = to_err_q;
    assign ovf_v[i]    = ovf_q;
  end

  // Sticky flag for multi-bit grants or grants landing on a channel not requesting.
  always_ff @(posedge n0 or posedge n1) begin
    if (n1) begin
      gnt_err_q <= 1'b0;
    end else if (((bus.gnt & (bus.gnt - NCH'(1))) != '0) || ((bus.gnt & ~req_v) != '0)) begin
      gnt_err_q <= 1'b1;
    end
  end

  assign bus.req     = req_v;
  assign bus.busy    = busy_v;
  assign bus.done    = done_v;
  assign bus.to_err  = to_err_v;
  assign bus.ovf     = ovf_v;
  assign bus.gnt_err = gnt_err_q;

endmodule

// File: tb/tb_req_client_bank.sv
// Directed bench for req_client_bank: inputs change and outputs are sampled on the falling edge.
module tb_req_client_bank;
  localparam int NCH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  req_client_bank_if bus ();

  req_client_bank dut (
    .n0  (clk),
    .n1  (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.job_v = '0;
    bus.job_len = '0;
    bus.gnt = '0;
    bus.tmo_limit = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.job_v = '0;
    bus.job_len = '0;
    bus.gnt = '0;
    bus.tmo_limit = '0;
    tick();
    checks++;
    if ({bus.req, bus.busy, bus.done, bus.to_err, bus.ovf, bus.gnt_err} !== 41'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %0h expected 0",
               {bus.req, bus.busy, bus.done, bus.to_err, bus.ovf, bus.gnt_err});
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.req, bus.busy, bus.done, bus.to_err, bus.ovf, bus.gnt_err} !== 41'd0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: got %0h expected 0",
               {bus.req, bus.busy, bus.done, bus.to_err, bus.ovf, bus.gnt_err});
    end
  endtask

  task automatic test_basic();
    bus.tmo_limit = '0;
    bus.job_len = 4'd3;
    bus.job_v = 8'h01;
    tick();
    bus.job_v = '0;
    checks++;
    if (bus.req !== 8'h00) begin
      errors++; $display("[TB] FAIL basic_req_e0: got %0h expected 00", bus.req);
    end
    tick();
    checks++;
    if (bus.req !== 8'h01) begin
      errors++; $display("[TB] FAIL basic_req_e1: got %0h expected 01", bus.req);
    end
    tick();
    checks++;
    if (bus.req !== 8'h01) begin
      errors++; $display("[TB] FAIL basic_req_e2: got %0h expected 01", bus.req);
    end
    bus.gnt = 8'h01;
    tick();
    bus.gnt = '0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.busy, bus.req, bus.done} !== {8'h01, 8'h00, 8'h00}) begin
        errors++;
        $display("[TB] FAIL basic_busy_%0d: got busy=%0h req=%0h done=%0h expected busy=01 req=00 done=00",
                 k, bus.busy, bus.req, bus.done);
      end
      tick();
    end
    checks++;
    if ({bus.busy, bus.done} !== {8'h00, 8'h01}) begin
      errors++;
      $display("[TB] FAIL basic_done: got busy=%0h done=%0h expected busy=00 done=01", bus.busy, bus.done);
    end
    tick();
    checks++;
    if ({bus.done, bus.req, bus.gnt_err} !== 17'd0) begin
      errors++;
      $display("[TB] FAIL basic_after_done: got done=%0h req=%0h gnt_err=%0b expected 0",
               bus.done, bus.req, bus.gnt_err);
    end
  endtask

  task automatic test_watchdog();
    bus.tmo_limit = 10'd5;
    bus.job_len = 4'd2;
    bus.job_v = 8'h08;
    tick();
    bus.job_v = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({bus.req, bus.to_err} !== {8'h08, 8'h00}) begin
        errors++;
        $display("[TB] FAIL wd_req_%0d: got req=%0h to_err=%0h expected req=08 to_err=00", k, bus.req, bus.to_err);
      end
    end
    tick();
    checks++;
    if ({bus.req, bus.to_err} !== {8'h00, 8'h08}) begin
      errors++;
      $display("[TB] FAIL wd_timeout: got req=%0h to_err=%0h expected req=00 to_err=08", bus.req, bus.to_err);
    end
    tick();
    checks++;
    if ({bus.req, bus.to_err, bus.busy} !== 24'd0) begin
      errors++;
      $display("[TB] FAIL wd_after: got req=%0h to_err=%0h busy=%0h expected 0", bus.req, bus.to_err, bus.busy);
    end
    bus.job_v = 8'h08;
    tick();
    bus.job_v = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus.req !== 8'h08) begin
        errors++; $display("[TB] FAIL wd2_req_%0d: got %0h expected 08", k, bus.req);
      end
      if (k == 4) bus.gnt = 8'h08;
    end
    tick();
    bus.gnt = '0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus.busy, bus.to_err} !== {8'h08, 8'h00}) begin
        errors++;
        $display("[TB] FAIL wd2_busy_%0d: got busy=%0h to_err=%0h expected busy=08 to_err=00", k, bus.busy, bus.to_err);
      end
      tick();
    end
    checks++;
    if ({bus.done, bus.busy, bus.to_err} !== {8'h08, 8'h00, 8'h00}) begin
      errors++;
      $display("[TB] FAIL wd2_done: got done=%0h busy=%0h to_err=%0h expected done=08 busy=00 to_err=00",
               bus.done, bus.busy, bus.to_err);
    end
    tick();
    bus.tmo_limit = '0;
  endtask

  task automatic test_queue_full();
    int exp_len [4] = '{1, 1, 2, 3};
    int n;
    bus.tmo_limit = '0;
    bus.job_len = 4'd0;
    bus.job_v = 8'h20;
    tick();
    bus.job_v = '0;
    tick();
    checks++;
    if (bus.req !== 8'h20) begin
      errors++; $display("[TB] FAIL qf_hold_req: got %0h expected 20", bus.req);
    end
    for (int j = 0; j < 4; j++) begin
      bus.job_len = 4'(j + 1);
      bus.job_v = 8'h20;
      tick();
      checks++;
      if (bus.ovf !== ((j == 3) ? 8'h20 : 8'h00)) begin
        errors++;
        $display("[TB] FAIL qf_ovf_%0d: got %0h expected %0h", j, bus.ovf, (j == 3) ? 8'h20 : 8'h00);
      end
    end
    bus.job_v = '0;
    tick();
    checks++;
    if (bus.ovf !== 8'h00) begin
      errors++; $display("[TB] FAIL qf_ovf_clear: got %0h expected 00", bus.ovf);
    end
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (bus.req[5] !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (bus.req[5] !== 1'b1) begin
        errors++; $display("[TB] FAIL qf_req_wait_%0d: got %0b expected 1", j, bus.req[5]);
      end
      bus.gnt = 8'h20;
      tick();
      bus.gnt = '0;
      n = 0;
      while (bus.busy[5] === 1'b1 && n < 20) begin
        n++;
        tick();
      end
      checks++;
      if (n != exp_len[j]) begin
        errors++; $display("[TB] FAIL qf_busy_len_%0d: got %0d expected %0d", j, n, exp_len[j]);
      end
      checks++;
      if (bus.done !== 8'h20) begin
        errors++; $display("[TB] FAIL qf_done_%0d: got %0h expected 20", j, bus.done);
      end
    end
    tick();
    checks++;
    if (bus.done !== 8'h00) begin
      errors++; $display("[TB] FAIL qf_done_clear: got %0h expected 00", bus.done);
    end
    repeat (6) tick();
    checks++;
    if ({bus.req, bus.busy} !== 16'd0) begin
      errors++; $display("[TB] FAIL qf_dropped_never_runs: got req=%0h busy=%0h expected 0", bus.req, bus.busy);
    end
  endtask

  task automatic test_gnt_err();
    do_reset();
    bus.job_len = 4'd1;
    bus.job_v = 8'h03;
    tick();
    bus.job_v = '0;
    tick();
    checks++;
    if ({bus.req, bus.gnt_err} !== {8'h03, 1'b0}) begin
      errors++; $display("[TB] FAIL ge_req: got req=%0h gnt_err=%0b expected req=03 gnt_err=0", bus.req, bus.gnt_err);
    end
    bus.gnt = 8'h03;
    tick();
    bus.gnt = '0;
    checks++;
    if ({bus.busy, bus.gnt_err} !== {8'h03, 1'b1}) begin
      errors++; $display("[TB] FAIL ge_multi: got busy=%0h gnt_err=%0b expected busy=03 gnt_err=1", bus.busy, bus.gnt_err);
    end
    repeat (4) tick();
    checks++;
    if ({bus.busy, bus.gnt_err} !== {8'h00, 1'b1}) begin
      errors++; $display("[TB] FAIL ge_sticky: got busy=%0h gnt_err=%0b expected busy=00 gnt_err=1", bus.busy, bus.gnt_err);
    end
    do_reset();
    checks++;
    if (bus.gnt_err !== 1'b0) begin
      errors++; $display("[TB] FAIL ge_reset_clear: got %0b expected 0", bus.gnt_err);
    end
    bus.gnt = 8'h80;
    tick();
    bus.gnt = '0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus.gnt_err, bus.req[7], bus.busy[7], bus.done[7]} !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL ge_stray_%0d: got gnt_err=%0b req7=%0b busy7=%0b done7=%0b expected 1,0,0,0",
                 k, bus.gnt_err, bus.req[7], bus.busy[7], bus.done[7]);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    bus.job_len = 4'd5;
    bus.job_v = 8'h04;
    tick();
    bus.job_v = '0;
    tick();
    bus.gnt = 8'h04;
    tick();
    bus.gnt = '0;
    tick();
    checks++;
    if (bus.busy !== 8'h04) begin
      errors++; $display("[TB] FAIL rmb_busy: got %0h expected 04", bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.req, bus.busy, bus.done, bus.to_err, bus.ovf, bus.gnt_err} !== 41'd0) begin
      errors++;
      $display("[TB] FAIL rmb_async: got %0h expected 0", {bus.req, bus.busy, bus.done, bus.to_err, bus.ovf, bus.gnt_err});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({bus.req, bus.busy, bus.done, bus.to_err} !== 32'd0) begin
        errors++;
        $display("[TB] FAIL rmb_after_%0d: got req=%0h busy=%0h done=%0h to_err=%0h expected 0",
                 k, bus.req, bus.busy, bus.done, bus.to_err);
      end
    end
  endtask

  task automatic test_concurrency();
    int bcnt [NCH];
    int rise [NCH];
    int dcnt [NCH];
    logic [NCH-1:0] prev;
    logic [NCH-1:0] side;
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      bcnt[c] = 0;
      rise[c] = 0;
      dcnt[c] = 0;
    end
    prev = '0;
    side = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.job_len = 4'(c + 1);
      bus.job_v = NCH'(1) << c;
      tick();
    end
    bus.job_v = '0;
    tick();
    checks++;
    if (bus.req !== 8'hFF) begin
      errors++; $display("[TB] FAIL cc_all_req: got %0h expected ff", bus.req);
    end
    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.busy[c] === 1'b1) bcnt[c]++;
        if (bus.busy[c] === 1'b1 && prev[c] !== 1'b1) rise[c]++;
        if (bus.done[c] === 1'b1) dcnt[c]++;
      end
      side = side | bus.to_err | bus.ovf;
      prev = bus.busy;
      bus.gnt = (k < NCH) ? (NCH'(1) << k) : '0;
      tick();
    end
    bus.gnt = '0;
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (bcnt[c] != c + 1 || rise[c] != 1 || dcnt[c] != 1) begin
        errors++;
        $display("[TB] FAIL cc_ch%0d: got busy_cycles=%0d windows=%0d dones=%0d expected %0d,1,1",
                 c, bcnt[c], rise[c], dcnt[c], c + 1);
      end
    end
    checks++;
    if ({side, bus.gnt_err, bus.req, bus.busy} !== 25'd0) begin
      errors++;
      $display("[TB] FAIL cc_side: got to_err|ovf=%0h gnt_err=%0b req=%0h busy=%0h expected 0",
               side, bus.gnt_err, bus.req, bus.busy);
    end
  endtask

  initial begin
    bus.job_v = '0;
    bus.job_len = '0;
    bus.gnt = '0;
    bus.tmo_limit = '0;
    test_reset();
    test_basic();
    test_watchdog();
    test_queue_full();
    test_gnt_err();
    test_reset_mid_busy();
    test_concurrency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_client_bank.md
Name: req_client_bank

Overview:
- Requester side of the one-hot request/grant handshake used by the grant/timeout arbiter block.
- Holds NCH independent client channels. Each channel queues jobs, raises req, waits for a one-hot grant, holds busy for the job length, then pulses done.
- A per-channel wait watchdog abandons a job that is never granted.
- Sits between job sources and the arbiter; req feeds the arbiter and gnt comes back from it.

Parameters:
- NCH, 8, number of client channels (width of req/gnt).
- CW, 10, width of the wait watchdog counter and tmo_limit.
- QD, 3, job queue depth per channel (2-bit occupancy).
- LW, 4, width of job length.

Ports:
- n0  input  1  clock, all state on rising edge
- n1  input  1  reset, asynchronous, active-high
- job_v  input  NCH  per-channel job enqueue strobe, one cycle per job
- job_len  input  LW  burst length for any channel enqueuing this cycle
- gnt  input  NCH  grant from arbiter, expected one-hot or zero
- tmo_limit  input  CW  wait-cycle limit before abandon; 0 = watchdog disabled
- req  output  NCH  request to arbiter
- busy  output  NCH  channel owns the resource
- done  output  NCH  one-cycle pulse at job completion
- to_err  output  NCH  one-cycle pulse when a job is abandoned by the watchdog
- ovf  output  NCH  one-cycle pulse when job_v is dropped because the queue is full
- gnt_err  output  1  sticky: grant seen that is not one-hot, or lands on a channel not in REQ

Behaviour:
- Reset (n1=1, async): all queues empty, all channel FSMs IDLE, all counters 0, all outputs 0. Mid-operation reset aborts every job with no done or to_err pulse.
- All outputs are registered; no combinational path from any input to any output.
- Queue, per channel:
  - FIFO of QD entries, each holding job_len.
  - job_v[i] enqueues on the edge.
  - job_v[i] with a full queue and no same-edge dequeue: job dropped, ovf[i]=1 for the next cycle.
  - Same-edge enqueue and dequeue with a full queue: job accepted, no ovf.
- Channel FSM states: IDLE, REQ, BUSY, DONE.
- IDLE:
  - Queue non-empty: dequeue head, latch len (len 0 treated as 1), clear wait counter, go to REQ.
  - A job enqueued into an empty queue at edge E0 therefore gives req high after edge E1.
- REQ: req[i]=1; wait counter increments each cycle.
  - gnt[i]=1 sampled: go to BUSY, load burst counter with len.
  - Otherwise, if tmo_limit!=0 and wait counter == tmo_limit-1: go to IDLE, job discarded, to_err[i]=1 for one cycle.
  - Grant and timeout on the same edge: grant wins.
  - Wait counter saturates at all-ones (only reachable with watchdog disabled).
- BUSY: busy[i]=1, req[i]=0; burst counter decrements each cycle; busy lasts exactly len cycles, then DONE.
- DONE:
  - done[i]=1 for one cycle, then IDLE.
  - A queued job therefore re-raises req two cycles after done.
- gnt_err:
  - Set when gnt has more than one bit high, or gnt[i]=1 while channel i is not in REQ.
  - Cleared only by reset.
  - Stray grant bits are otherwise ignored.
  - With a multi-bit gnt, every granted channel in REQ still proceeds to BUSY.
- Channels are fully independent; simultaneous events on different channels do not interact.

Test Plan:
- Reset mid-BUSY on channel 2 → all outputs 0 immediately (async), no done[2]; after release, req=0 until a new job_v.
- Basic handshake:
  - Stimulus: job_v=8'h01, job_len=3, tmo_limit=0; gnt=8'h01 two cycles after req rises.
  - Required: req[0] high 2 edges after job_v, drops when busy[0] rises.
  - Required: busy[0] high for exactly 3 cycles, then done[0] for exactly 1 cycle.
- Watchdog:
  - Stimulus: tmo_limit=5, job on channel 3, never granted.
  - Required: req[3] high exactly 5 cycles, then to_err[3] pulses once; req[3]=0 with an empty queue.
  - Repeat with gnt[3] on the 5th req cycle → BUSY, no to_err.
- Queue full:
  - Stimulus: 4 back-to-back job_v on channel 5 (len 1,2,3,4) while held in REQ with no grant and tmo_limit=0.
  - Required: 4th job_v produces ovf[5]=1.
  - After granting each in turn: busy lengths are 1, 2, 3 and the dropped job never runs.
  - Required: job_len=0 produces busy of 1 cycle.
- Grant errors:
  - Stimulus: gnt=8'h03 with channels 0 and 1 in REQ.
  - Required: both enter BUSY, gnt_err=1 and stays 1 until reset.
  - Stimulus: gnt=8'h80 with channel 7 IDLE.
  - Required: gnt_err set, channel 7 unaffected.
- Concurrency: jobs on all 8 channels with a rotating one-hot grant → each channel has exactly one busy window of its len and one done pulse; no cross-channel interference.
